// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, the timing-set struct used to
// parameterise the generator, and a sync polarity helper.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam logic        SYNC_ACTIVE = 1'b0;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam int POS_W = 10;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        sync_active;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{
        h_active: H_ACTIVE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_active: V_ACTIVE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP,
        sync_active: SYNC_ACTIVE
    };

    // Drive the pulse level when active, the idle level otherwise.
    function automatic logic sync_level(input logic active, input logic sync_active);
        return active ? sync_active : ~sync_active;
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Mod-N counter that parks at N-1 in reset so the first increment lands on 0.
// wrap flags the increment that returns the count to 0.
module vga_wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int N = 800,
    parameter int W = POS_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    assign wrap  = inc && (count_reg == W'(N - 1));
    assign count = count_reg;

    always_comb begin
        count_next = count_reg;
        if (inc) begin
            count_next = wrap ? '0 : count_reg + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= W'(N - 1);
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: hpos/vpos counters plus sync, display and
// start flags, all registered so every flag matches the position beside it.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter vga_timing_t TIMING = VGA_640X480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_cnt
);

    localparam int unsigned LINE_LEN    = TIMING.h_active + TIMING.h_fp + TIMING.h_sync + TIMING.h_bp;
    localparam int unsigned FRAME_LINES = TIMING.v_active + TIMING.v_fp + TIMING.v_sync + TIMING.v_bp;
    localparam int unsigned HSYNC_BEGIN = TIMING.h_active + TIMING.h_fp;
    localparam int unsigned HSYNC_END   = HSYNC_BEGIN + TIMING.h_sync;
    localparam int unsigned VSYNC_BEGIN = TIMING.v_active + TIMING.v_fp;
    localparam int unsigned VSYNC_END   = VSYNC_BEGIN + TIMING.v_sync;
    localparam logic        SYNC_IDLE   = ~TIMING.sync_active;

    logic [POS_W-1:0] h_count;
    logic [POS_W-1:0] v_count;
    logic             h_wrap;
    logic             v_wrap;
    logic [POS_W-1:0] h_next;
    logic [POS_W-1:0] v_next;

    logic             hsync_reg;
    logic             vsync_reg;
    logic             display_on_reg;
    logic             line_start_reg;
    logic             frame_start_reg;
    logic [7:0]       frame_cnt_reg;

    vga_wrap_counter #(.N(int'(LINE_LEN)), .W(POS_W)) u_h_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (ena),
        .count (h_count),
        .wrap  (h_wrap)
    );

    vga_wrap_counter #(.N(int'(FRAME_LINES)), .W(POS_W)) u_v_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (h_wrap),
        .count (v_count),
        .wrap  (v_wrap)
    );

    // Mirror of the counters' next values so flags can be registered in step.
    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (ena) begin
            h_next = h_wrap ? '0 : h_count + POS_W'(1);
        end
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_count + POS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_reg       <= SYNC_IDLE;
            vsync_reg       <= SYNC_IDLE;
            display_on_reg  <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_cnt_reg   <= 8'hFF;
        end else begin
            hsync_reg       <= sync_level((h_next >= POS_W'(HSYNC_BEGIN)) && (h_next < POS_W'(HSYNC_END)),
                                          TIMING.sync_active);
            vsync_reg       <= sync_level((v_next >= POS_W'(VSYNC_BEGIN)) && (v_next < POS_W'(VSYNC_END)),
                                          TIMING.sync_active);
            display_on_reg  <= (h_next < POS_W'(TIMING.h_active)) && (v_next < POS_W'(TIMING.v_active));
            line_start_reg  <= (h_next == '0);
            frame_start_reg <= (h_next == '0) && (v_next == '0);
            if (v_wrap) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
        end
    end

    assign hpos        = h_count;
    assign vpos        = v_count;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign display_on  = display_on_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA 640x480@60 raster timing (25 MHz pixel clock) for the tt_um_embeddedinn_vga top.
- Directly upstream of the pixel/pattern stage: supplies hpos/vpos, display_on and the sync strobes.
- The pattern stage consumes these and drives the RGB outputs on uo_out.
- All outputs are registered, and every output is a consistent decode of the hpos/vpos presented in the same cycle.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- SYNC_ACTIVE, 0, sync pulse polarity (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  pixel advance enable; when low, all state holds
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity set by SYNC_ACTIVE
- vsync  out  1  vertical sync, polarity set by SYNC_ACTIVE
- display_on  out  1  high when hpos<H_ACTIVE and vpos<V_ACTIVE
- line_start  out  1  high while hpos==0
- frame_start  out  1  high while hpos==0 and vpos==0
- frame_cnt  out  8  frame counter, wraps modulo 256

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Reset state parks the raster at the last position of the frame:
  - hpos=H_TOTAL-1 (799), vpos=V_TOTAL-1 (524).
  - hsync and vsync inactive (1 for SYNC_ACTIVE=0).
  - display_on=0, line_start=0, frame_start=0, frame_cnt=8'hFF.
- First clock edge with rst=0 and ena=1 moves to (0,0) and produces:
  - display_on=1, line_start=1, frame_start=1, frame_cnt=0.
  - Every frame, including the first, therefore begins with a visible frame_start.
- Advance rule, on each edge with ena=1 and rst=0:
  - hpos increments.
  - At hpos==H_TOTAL-1, hpos wraps to 0 and vpos increments.
  - At vpos==V_TOTAL-1 together with the h-wrap, vpos wraps to 0 and frame_cnt increments. frame_cnt wraps 255->0.
- ena=0: hpos, vpos, frame_cnt and all flags hold their values. A level output such as line_start therefore remains high across stalled cycles; consumers must qualify pulses with ena.
- hsync is active for H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- vsync is active for V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491. It is line-based and independent of hpos.
- Output flags are computed from the next-state counter values and registered alongside the counters. There is zero relative skew between hpos/vpos and any flag, and no combinational path from inputs to outputs.
- rst asserted mid-frame: on the next edge, all outputs return to the reset state regardless of ena. rst takes priority over ena.
- Counter widths: 10 bits is sufficient for both axes (max 799). All compares are unsigned, and no counter value outside 0..TOTAL-1 is ever reachable.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the porch/sync/active constants;
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - POS_W=10.
- One sub-module, vga_wrap_counter: a parameterised mod-N counter with inputs clk, rst, inc and outputs count and wrap (wrap = inc & count==N-1).
  - Instantiated twice: horizontal with inc=ena, vertical with inc = horizontal wrap.
- Sync, display_on and start flags are decoded in vga_timing_gen.

Test Plan:
- Reset then release with ena=1 -> cycle after release: hpos=0, vpos=0, display_on=1, frame_start=1, frame_cnt=0, hsync=vsync=1.
- Free run one line -> hsync=0 exactly for hpos 656..751 (96 cycles); display_on=0 from hpos 640; hpos 799 -> 0 with vpos 0 -> 1.
- Free run full frame (420000 cycles) -> vsync=0 for vpos 490..491 only (1600 cycles); frame_start high once per frame; frame_cnt=1 at second (0,0).
- Toggle ena 1/0 every cycle across hpos 798..1 -> every hold cycle shows unchanged hpos and flags; line wrap occurs only on an ena=1 edge.
- Assert rst at hpos=700, vpos=300 with ena=0 -> next edge hpos=799, vpos=524, frame_cnt=8'hFF, all flags in the reset state.
- Run 256 frames -> frame_cnt wraps 255 -> 0; hpos/vpos never exceed 799/524 (assertion).
